adc_spi_reader: RTL and testbench
=================================

# adc_spi_reader

- Periodically reads one 12-bit sample from an external serial ADC through an SPI-style link (SCLK idle low, chip select active low, data on MISO).
- Presents the sample as a held 12-bit level `o_Lv` with a one-cycle `o_Valid` strobe.
- Sits directly upstream of the level-threshold pulse stage: `o_Lv` feeds its 12-bit level input `i_Lv`.

## Interface
- `CLK_DIV`, default 4: `i_CLK` cycles per SCLK half-period; legal range ≥ 2.
- `SAMPLE_PERIOD`, default 1000: `i_CLK` cycles between conversion starts; must be ≥ 33*CLK_DIV + 2.
- `i_CLK` input, 1 bit: system clock; all logic on its rising edge.
- `i_RST` input, 1 bit: reset, asynchronous, active-low.
- `i_EN` input, 1 bit: 1 = periodic conversions enabled.
- `i_MISO` input, 1 bit: ADC serial data, MSB first.
- `o_CS_n` output, 1 bit: ADC chip select, active low.
- `o_SCLK` output, 1 bit: ADC serial clock.
- `o_Lv` output, 12 bits: last completed sample, unsigned, held between updates.
- `o_Valid` output, 1 bit: high for exactly one cycle when `o_Lv` updates.
- `o_Busy` output, 1 bit: high while a frame is in progress (`o_CS_n` low).

## Operation
- **Sample timer:** free-running, counts 0..SAMPLE_PERIOD-1 then wraps to 0, regardless of `i_EN` or state.
  - A tick is the cycle where timer == SAMPLE_PERIOD-1.
  - The timer width is the smallest width that holds SAMPLE_PERIOD-1.
- **States:** IDLE, SETUP, SHIFT, DONE.
- **IDLE:** `o_CS_n`=1, `o_SCLK`=0. Goes to SETUP on a tick with `i_EN`=1. A tick with `i_EN`=0 is ignored.
- **SETUP:** `o_CS_n`=0, `o_SCLK`=0 for CLK_DIV cycles, then goes to SHIFT.
- **SHIFT:** 16 bit periods of 2*CLK_DIV cycles each.
  - Each bit period is CLK_DIV cycles of `o_SCLK`=0, then CLK_DIV cycles of `o_SCLK`=1.
  - `i_MISO` is captured in the cycle where `o_SCLK` goes 0→1, shifted left into a 16-bit register (LSB in).
  - Goes to DONE after the high phase of bit 16 ends.
- **DONE:** lasts one cycle.
  - `o_CS_n`=1 and `o_SCLK`=0.
  - `o_Lv` ← shift[12:1], which is rising edges 4..15, MSB first.
  - `o_Valid`=1 for this cycle.
  - Returns to IDLE.
- **Ignored bits:** edges 1–3 (sample/null bits) and edge 16 are discarded. Their values must never reach `o_Lv`.
- **Capture timing:** `i_MISO` is sampled directly with no synchronizer, because the ADC drives it relative to our own SCLK.
- **`i_EN` deasserted mid-frame:** the frame completes normally. No new frame starts until a tick with `i_EN`=1.
- **`o_Busy`:** equals NOT `o_CS_n`.
- **Reset (any time, including mid-frame):** asynchronous.
  - State → IDLE, timer = 0, shift register = 0.
  - `o_CS_n`=1, `o_SCLK`=0, `o_Lv`=0, `o_Valid`=0, `o_Busy`=0.
  - The aborted frame produces no `o_Valid` and does not change `o_Lv`.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Let T be the tick cycle that starts a frame:
  - `o_CS_n` falls at T+1 and stays low through T+33*CLK_DIV.
  - First `o_SCLK` rise is at T+2*CLK_DIV+1.
  - The k-th rise (k = 1..16) is at T+CLK_DIV+(2k-1)*CLK_DIV+1.
  - `o_Valid`=1 and new `o_Lv` appear at T+33*CLK_DIV+1; `o_CS_n` returns high in that same cycle.
  - With CLK_DIV=4: valid at T+133.
- `o_CS_n` high time between frames is ≥ SAMPLE_PERIOD − 33*CLK_DIV ≥ 2 cycles.
- After reset release, the first tick occurs SAMPLE_PERIOD cycles later (timer counts from 0).
- `o_Lv` is stable for SAMPLE_PERIOD cycles between `o_Valid` pulses when `i_EN`=1 continuously.

## Test plan
- **Reset values:** assert `i_RST`=0 mid-run → outputs immediately `o_CS_n`=1, `o_SCLK`=0, `o_Lv`=0, `o_Valid`=0, `o_Busy`=0 without waiting for a clock edge.
- **Basic conversion:** CLK_DIV=4, SAMPLE_PERIOD=200; ADC model drives 3 leading bits, then 12'd2001 MSB first, then a trailing bit, changing on SCLK falling edges → exactly 16 SCLK rises while `o_CS_n` is low; `o_CS_n` low T+1..T+132; `o_Valid` at T+133 for one cycle; `o_Lv`=2001.
- **Ignored bits:** leading 3 bits and trailing bit driven 1, data 12'h000 → `o_Lv`=0. Then all ignored bits 0, data 12'hFFF → `o_Lv`=4095.
- **Periodic cadence:** `i_EN`=1 continuously for 5 frames → `o_Valid` pulses exactly 200 cycles apart; first pulse at reset-release+200+133.
- **Enable handling:** drop `i_EN` at frame cycle 40 → frame completes with a correct `o_Lv` and no further `o_CS_n` activity. Re-raise `i_EN` → the next frame starts on the next tick, not immediately.
- **Reset mid-SHIFT:** assert reset at T+60 → `o_CS_n`=1 and `o_SCLK`=0 at once, no `o_Valid`, `o_Lv`=0. After release, the next frame starts 200 cycles later and yields the correct sample.

Source files
------------

// File: rtl/adc_spi_reader.sv
// ----------------------------------------------------------------------------
// adc_spi_reader
//
// Periodically reads one 12-bit sample from an external serial ADC over an
// SPI-style link (SCLK idle low, chip select active low, MSB first on MISO).
// A 16-bit frame is clocked in; rising edges 4..15 carry the sample and are
// presented on o_Lv with a one-cycle o_Valid strobe. o_Lv feeds the 12-bit
// level input of the downstream level-threshold pulse stage.
//
// Parameters
//   CLK_DIV        i_CLK cycles per SCLK half-period (>= 2)
//   SAMPLE_PERIOD  i_CLK cycles between conversion starts (>= 33*CLK_DIV+2)
//
// Ports
//   i_CLK    system clock, rising edge
//   i_RST    asynchronous active-low reset
//   i_EN     1 = periodic conversions enabled
//   i_MISO   ADC serial data
//   o_CS_n   ADC chip select, active low
//   o_SCLK   ADC serial clock
//   o_Lv     last completed 12-bit sample, held between updates
//   o_Valid  one-cycle strobe when o_Lv updates
//   o_Busy   high while a frame is in progress (o_CS_n low)
// ----------------------------------------------------------------------------
module adc_spi_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_EN,
  input  logic        i_MISO,
  output logic        o_CS_n,
  output logic        o_SCLK,
  output logic [11:0] o_Lv,
  output logic        o_Valid,
  output logic        o_Busy
);

  // Smallest widths that hold SAMPLE_PERIOD-1 and CLK_DIV-1.
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q,   cnt_d;     // cycles within the current SCLK half-period
  logic [3:0]    bit_q,   bit_d;     // bit period index 0..15
  logic [15:0]   shift_q, shift_d;
  logic          cs_n_q,  cs_n_d;
  logic          sclk_q,  sclk_d;
  logic [11:0]   lv_q,    lv_d;
  logic          valid_q, valid_d;
  logic          tick;

  assign tick = (timer_q == TIMER_LAST);

  // --------------------------------------------------------------------------
  // State and output registers. Every output is driven straight from a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      lv_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      lv_q    <= lv_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Outputs are computed one cycle ahead so that the
  // registered values line up with the state they belong to.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    lv_d    = lv_q;
    valid_d = 1'b0;
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;

    // Free-running sample timer, independent of i_EN and of the FSM.
    timer_d = tick ? '0 : timer_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (tick && i_EN) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
        end
      end

      SETUP: begin
        cs_n_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = sclk_q;
        // First cycle with SCLK high: the ADC changed MISO on the previous
        // falling edge, so the bit is settled here. No synchronizer is used
        // because MISO is launched from our own SCLK.
        if (sclk_q && (cnt_q == '0)) begin
          shift_d = {shift_q[14:0], i_MISO};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 4'd15) begin
            // End of the high phase of bit 16. The last capture happened
            // earlier in this phase, so shift_q is complete. Bits 15..13
            // (edges 1-3) and bit 0 (edge 16) are dropped.
            state_d = DONE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            lv_d    = shift_q[12:1];
            valid_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_CS_n  = cs_n_q;
  assign o_SCLK  = sclk_q;
  assign o_Lv    = lv_q;
  assign o_Valid = valid_q;
  assign o_Busy  = ~cs_n_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// ----------------------------------------------------------------------------
// tb_adc_spi_reader
//
// Directed sequence with randomized ADC words. A behavioural ADC model shifts
// out a 16-bit frame {3 leading bits, 12 data bits, 1 trailing bit} on SCLK
// falling edges; the expected level is simply the data field. Frame timing is
// checked against the absolute cycle numbers derived from the tick rule
// (ticks land on cycles where cycle % SAMPLE_PERIOD == SAMPLE_PERIOD-1,
// counting from reset release).
// ----------------------------------------------------------------------------
module tb_adc_spi_reader;

  localparam int CD = 4;
  localparam int P  = 200;
  localparam int FIRST_VALID = (P - 1) + 33 * CD + 1;  // tick cycle + 133

  logic        i_CLK;
  logic        i_RST;
  logic        i_EN;
  logic        i_MISO;
  logic        o_CS_n;
  logic        o_SCLK;
  logic [11:0] o_Lv;
  logic        o_Valid;
  logic        o_Busy;

  int tests;
  int fails;

  adc_spi_reader #(
    .CLK_DIV      (CD),
    .SAMPLE_PERIOD(P)
  ) dut (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_EN   (i_EN),
    .i_MISO (i_MISO),
    .o_CS_n (o_CS_n),
    .o_SCLK (o_SCLK),
    .o_Lv   (o_Lv),
    .o_Valid(o_Valid),
    .o_Busy (o_Busy)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // Cycle number since reset release; during the first cycle after release
  // it is 0, matching the DUT timer's start value.
  int cyc;
  always @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- behavioural ADC ----------------
  logic [15:0] adc_word;
  logic [15:0] frame_word;
  int          adc_idx;
  logic        adc_sclk_last = 1'b0;

  always @(o_CS_n or o_SCLK or adc_word) begin
    if (o_CS_n) begin
      adc_idx    = 0;
      frame_word = adc_word;
    end else if (adc_sclk_last && !o_SCLK) begin
      adc_idx = adc_idx + 1;
    end
    adc_sclk_last = o_SCLK;
    i_MISO = (adc_idx < 16) ? frame_word[4'(15 - adc_idx)] : 1'b0;
  end

  // ---------------- bus monitor (negedge sampling) ----------------
  logic cs_prev = 1'b1, sclk_prev = 1'b0, valid_prev = 1'b0;
  int cs_fall_cnt = 0, cs_fall_cyc = 0, rises = 0, cur_low = 0;
  int valid_cnt = 0, valid_cyc = 0, valid_rises = 0, valid_low = 0;
  int valid_lv = 0, valid_long = 0, busy_err = 0;

  always @(negedge i_CLK) begin
    if (o_Busy !== ~o_CS_n) busy_err <= busy_err + 1;
    if (!o_CS_n && cs_prev) begin
      cs_fall_cnt <= cs_fall_cnt + 1;
      cs_fall_cyc <= cyc;
      rises       <= 0;
      cur_low     <= 1;
    end else if (!o_CS_n) begin
      cur_low <= cur_low + 1;
      if (o_SCLK && !sclk_prev) rises <= rises + 1;
    end
    if (o_Valid) begin
      if (valid_prev) valid_long <= valid_long + 1;
      valid_cnt   <= valid_cnt + 1;
      valid_cyc   <= cyc;
      valid_lv    <= int'(o_Lv);
      valid_rises <= rises;
      valid_low   <= cur_low;
    end
    cs_prev    <= o_CS_n;
    sclk_prev  <= o_SCLK;
    valid_prev <= o_Valid;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int start;
    int n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < budget) begin
      step();
      n++;
    end
    tests++;
    assert (valid_cnt != start) else begin
      fails++;
      $error("FAIL %s: observed no o_Valid within %0d cycles, expected one", tag, budget);
    end
  endtask

  task automatic wait_cs_fall(input int budget, input string tag);
    int start;
    int n;
    start = cs_fall_cnt;
    n = 0;
    while (cs_fall_cnt == start && n < budget) begin
      step();
      n++;
    end
    tests++;
    assert (cs_fall_cnt != start) else begin
      fails++;
      $error("FAIL %s: observed no o_CS_n fall within %0d cycles, expected one", tag, budget);
    end
  endtask

  task automatic wait_cyc(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (cyc != target && n < budget) begin
      step();
      n++;
    end
    tests++;
    assert (cyc == target) else begin
      fails++;
      $error("FAIL %s: observed cycle %0d expected %0d", tag, cyc, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},  32'(o_CS_n),  32'd1);
    check({tag, "_sclk"},  32'(o_SCLK),  32'd0);
    check({tag, "_lv"},    32'(o_Lv),    32'd0);
    check({tag, "_valid"}, 32'(o_Valid), 32'd0);
    check({tag, "_busy"},  32'(o_Busy),  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          prev_valid;
    int          frame_f;
    int          saved;
    int          r;
    logic [2:0]  lead;
    logic [11:0] data;
    logic        trail;

    tests    = 0;
    fails    = 0;
    i_EN     = 1'b0;
    i_RST    = 1'b1;
    adc_word = 16'h0000;

    // Reset asserted between clock edges must act immediately.
    #2 i_RST = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) step();

    // Frame 1: 3 leading bits, 2001, trailing bit.
    @(negedge i_CLK);
    i_RST    = 1'b1;
    i_EN     = 1'b1;
    adc_word = {3'b101, 12'd2001, 1'b0};
    wait_valid(FIRST_VALID + 20, "frame1_wait");
    check("frame1_valid_cyc", 32'(valid_cyc),   32'(FIRST_VALID));
    check("frame1_csfall",    32'(cs_fall_cyc), 32'(P));
    check("frame1_cs_low",    32'(valid_low),   32'(33 * CD));
    check("frame1_rises",     32'(valid_rises), 32'd16);
    check("frame1_lv",        32'(o_Lv),        32'd2001);
    step();
    check("frame1_valid_1cyc", 32'(o_Valid), 32'd0);
    check("frame1_lv_hold",    32'(o_Lv),    32'd2001);
    $display("[TB] frame1 lv=%0d valid_cyc=%0d", valid_lv, valid_cyc);
    prev_valid = valid_cyc;

    // Ignored bits all 1, data 0.
    adc_word = {3'b111, 12'h000, 1'b1};
    wait_valid(P + 20, "ign1_wait");
    check("ign1_lv",     32'(o_Lv),                   32'd0);
    check("ign1_period", 32'(valid_cyc - prev_valid), 32'(P));
    $display("[TB] ignored-ones frame lv=%0d", valid_lv);
    prev_valid = valid_cyc;

    // Ignored bits all 0, data full scale.
    adc_word = {3'b000, 12'hFFF, 1'b0};
    wait_valid(P + 20, "ign0_wait");
    check("ign0_lv",     32'(o_Lv),                   32'd4095);
    check("ign0_period", 32'(valid_cyc - prev_valid), 32'(P));
    $display("[TB] ignored-zeros frame lv=%0d", valid_lv);
    prev_valid = valid_cyc;

    // Randomized frames at the continuous cadence.
    for (int i = 0; i < 4; i++) begin
      lead     = 3'($urandom_range(0, 7));
      data     = 12'($urandom_range(0, 4095));
      trail    = 1'($urandom_range(0, 1));
      adc_word = {lead, data, trail};
      wait_valid(P + 20, "rand_wait");
      check("rand_lv",     32'(o_Lv),                   32'(data));
      check("rand_period", 32'(valid_cyc - prev_valid), 32'(P));
      check("rand_rises",  32'(valid_rises),            32'd16);
      $display("[TB] random frame %0d word=%h lv=%0d expected=%0d", i, adc_word, valid_lv, data);
      prev_valid = valid_cyc;
    end

    // Drop i_EN at frame cycle 40; the frame must still complete.
    adc_word = {3'b010, 12'hA5C, 1'b1};
    wait_cs_fall(P + 20, "en_frame_start");
    frame_f = cs_fall_cyc;
    wait_cyc(frame_f + 39, 100, "en_drop_point");
    i_EN = 1'b0;
    wait_valid(P, "en_frame_wait");
    check("en_frame_lv",    32'(o_Lv),                32'h0A5C);
    check("en_frame_valid", 32'(valid_cyc - frame_f), 32'(33 * CD));
    $display("[TB] enable-drop frame lv=%0d", valid_lv);
    saved = cs_fall_cnt;
    repeat (2 * P) step();
    while (cyc % P != 50) step();
    check("en_off_no_frame", 32'(cs_fall_cnt), 32'(saved));
    check("en_off_cs_high",  32'(o_CS_n),      32'd1);

    // Re-raise i_EN mid-period: the frame waits for the next tick.
    r        = cyc;
    adc_word = {3'b001, 12'd1234, 1'b0};
    i_EN     = 1'b1;
    wait_cs_fall(2 * P, "en_restart");
    check("en_restart_cyc", 32'(cs_fall_cyc), 32'(r - 50 + P));
    wait_valid(P, "en_restart_wait");
    check("en_restart_lv", 32'(o_Lv), 32'd1234);
    $display("[TB] re-enabled frame start=%0d lv=%0d", cs_fall_cyc, valid_lv);

    // Reset in the middle of SHIFT (SCLK high during rise 7 at T+60).
    data     = 12'($urandom_range(1, 4095));
    adc_word = {3'b011, data, 1'b1};
    wait_cs_fall(P + 20, "rst_frame_start");
    frame_f = cs_fall_cyc;           // T+1
    wait_cyc(frame_f + 59, 100, "rst_point");
    check("rst_pre_sclk", 32'(o_SCLK), 32'd1);
    saved = valid_cnt;
    i_RST = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) step();
    check("rst_no_valid", 32'(valid_cnt), 32'(saved));
    @(negedge i_CLK);
    i_RST    = 1'b1;
    adc_word = {3'b110, 12'd3210, 1'b1};
    wait_valid(FIRST_VALID + 20, "post_rst_wait");
    check("post_rst_valid_cyc", 32'(valid_cyc),   32'(FIRST_VALID));
    check("post_rst_csfall",    32'(cs_fall_cyc), 32'(P));
    check("post_rst_lv",        32'(o_Lv),        32'd3210);
    check("post_rst_count",     32'(valid_cnt),   32'(saved + 1));
    $display("[TB] post-reset frame lv=%0d valid_cyc=%0d", valid_lv, valid_cyc);

    // Whole-run invariants.
    check("valid_single_cycle", 32'(valid_long), 32'd0);
    check("busy_eq_not_cs",     32'(busy_err),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
